// File: rtl/fp32_mul_normround.sv
// Normalize / round-to-nearest-even / pack stage that follows the 24x24 mantissa
// multiplier of the FP32 multiply datapath. Two registered stages with valid/ready.
module fp32_mul_normround #(
  parameter bit          ROUND_EN = 1'b1,
  parameter logic [31:0] QNAN     = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [49:0] in_prod,
  input  logic [9:0]  in_exp_sum,
  input  logic        in_sign,
  input  logic [1:0]  in_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
);

  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  // Stage 1 registers (normalized mantissa, guard/sticky, adjusted exponent)
  logic        r_s1_valid;
  logic [23:0] r_s1_mant;
  logic        r_s1_guard;
  logic        r_s1_sticky;
  logic [9:0]  r_s1_exp;
  logic        r_s1_sign;
  logic [1:0]  r_s1_class;

  // Stage 2 registers (packed result and flags)
  logic        r_s2_valid;
  logic [31:0] r_s2_result;
  logic        r_s2_ovf;
  logic        r_s2_unf;
  logic        r_s2_inexact;

  logic        w_s2_ready;
  logic [23:0] w_s1_mant;
  logic        w_s1_guard;
  logic        w_s1_sticky;
  logic [9:0]  w_s1_exp;

  logic        w_round_up;
  logic [24:0] w_mant_sum;
  logic        w_carry;
  logic [23:0] w_mant_r;
  logic signed [9:0] w_exp_r;
  logic [31:0] w_result;
  logic        w_ovf;
  logic        w_unf;
  logic        w_inexact;
  logic        w_unused;

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;

  // The product of two normalized mantissas lies in [1,4), so the leading one
  // sits at bit 47 or bit 46.
  always_comb begin
    if (in_prod[47]) begin
      w_s1_mant   = in_prod[47:24];
      w_s1_guard  = in_prod[23];
      w_s1_sticky = |in_prod[22:0];
      w_s1_exp    = in_exp_sum + 10'd1;
    end else begin
      w_s1_mant   = in_prod[46:23];
      w_s1_guard  = in_prod[22];
      w_s1_sticky = |in_prod[21:0];
      w_s1_exp    = in_exp_sum;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_mant   <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_sign   <= 1'b0;
      r_s1_class  <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        r_s1_mant   <= w_s1_mant;
        r_s1_guard  <= w_s1_guard;
        r_s1_sticky <= w_s1_sticky;
        r_s1_exp    <= w_s1_exp;
        r_s1_sign   <= in_sign;
        r_s1_class  <= in_class;
      end
    end
  end

  assign w_round_up = ROUND_EN & r_s1_guard & (r_s1_sticky | r_s1_mant[0]);
  assign w_mant_sum = {1'b0, r_s1_mant} + {24'd0, w_round_up};
  assign w_carry    = w_mant_sum[24];
  assign w_mant_r   = w_carry ? 24'h80_0000 : w_mant_sum[23:0];
  assign w_exp_r    = $signed(r_s1_exp + {9'd0, w_carry});

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_result  = '0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    w_inexact = 1'b0;
    case (r_s1_class)
      CLS_ZERO: w_result = {r_s1_sign, 31'h0};
      CLS_INF:  w_result = {r_s1_sign, 8'hFF, 23'h0};
      CLS_NAN:  w_result = QNAN;
      default: begin
        w_inexact = r_s1_guard | r_s1_sticky;
        if (w_exp_r >= 10'sd255) begin
          w_result  = {r_s1_sign, 8'hFF, 23'h0};
          w_ovf     = 1'b1;
          w_inexact = 1'b1;
        end else if (w_exp_r <= 10'sd0) begin
          // No subnormal support: anything below the normal range flushes to zero.
          w_result  = {r_s1_sign, 31'h0};
          w_unf     = 1'b1;
          w_inexact = 1'b1;
        end else begin
          w_result = {r_s1_sign, w_exp_r[7:0], w_mant_r[22:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_result  <= '0;
      r_s2_ovf     <= 1'b0;
      r_s2_unf     <= 1'b0;
      r_s2_inexact <= 1'b0;
    end else begin
      if (w_s2_ready) r_s2_valid <= r_s1_valid;
      if (r_s1_valid && w_s2_ready) begin
        r_s2_result  <= w_result;
        r_s2_ovf     <= w_ovf;
        r_s2_unf     <= w_unf;
        r_s2_inexact <= w_inexact;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_result  = r_s2_result;
  assign out_ovf     = r_s2_ovf;
  assign out_unf     = r_s2_unf;
  assign out_inexact = r_s2_inexact;

  // Product bits [49:48] are always zero; the hidden bit of the rounded mantissa is implicit.
  assign w_unused = ^{in_prod[49:48], w_mant_r[23]};

endmodule
